// File: rtl/seg7_scan_driver.sv
// Multiplexed scan driver for an active-low 7-segment display, feeding an external hexToSeg7 decoder.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int ON_CYCLES   = 1000,
    parameter int DEAD_CYCLES = 16,
    parameter int CW          = 16
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                enable,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dpIn,
    output logic [3:0]          hexOut,
    input  logic [6:0]          segIn,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   digitN,
    output logic                frameDone
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_counter;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_shadowVal;
    logic [DIGITS-1:0]     r_shadowDp;
    logic [4*DIGITS-1:0]   r_activeVal;
    logic [DIGITS-1:0]     r_activeDp;
    logic                  r_pending;
    logic [3:0]            r_hexOut;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [DIGITS-1:0]     r_digitN;
    logic                  r_frameDone;

    logic                  w_onExit;
    logic                  w_wrap;
    logic [IW-1:0]         w_idxNext;
    logic [4*DIGITS-1:0]   w_activeValNext;
    logic [DIGITS-1:0]     w_activeDpNext;
    logic                  w_pendingNext;
    logic                  w_lit;

    // A load on the wrap edge bypasses the shadow so the new frame shows it at once.
    always_comb begin
        w_onExit        = enable && (r_state == ST_ON) && (r_counter == ON_LAST);
        w_wrap          = w_onExit && (r_idx == IDX_LAST);
        w_idxNext       = r_idx;
        w_activeValNext = r_activeVal;
        w_activeDpNext  = r_activeDp;
        w_pendingNext   = r_pending;
        if (!enable)
            w_idxNext = '0;
        else if (w_onExit)
            w_idxNext = w_wrap ? '0 : r_idx + IW'(1);
        if (w_wrap) begin
            w_pendingNext = 1'b0;
            if (load) begin
                w_activeValNext = value;
                w_activeDpNext  = dpIn;
            end else if (r_pending) begin
                w_activeValNext = r_shadowVal;
                w_activeDpNext  = r_shadowDp;
            end
        end else if (load) begin
            w_pendingNext = 1'b1;
        end else if (!enable && r_pending) begin
            w_activeValNext = r_shadowVal;
            w_activeDpNext  = r_shadowDp;
            w_pendingNext   = 1'b0;
        end
    end

`ifdef SEG7_SCAN_LZB_EN
    logic [DIGITS:0] w_zeroFrom;

    // w_zeroFrom[i]: digits i and above are all zero with no decimal point set.
    always_comb begin
        w_zeroFrom[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--)
            w_zeroFrom[i] = w_zeroFrom[i+1] && (r_activeVal[4*i +: 4] == 4'h0) && !r_activeDp[i];
        w_lit = (r_idx == '0) || !w_zeroFrom[r_idx];
    end
`else
    assign w_lit = 1'b1;
`endif

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_BLANK;
            r_counter   <= '0;
            r_idx       <= '0;
            r_shadowVal <= '0;
            r_shadowDp  <= '0;
            r_activeVal <= '0;
            r_activeDp  <= '0;
            r_pending   <= 1'b0;
            r_hexOut    <= 4'h0;
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
            r_digitN    <= '1;
            r_frameDone <= 1'b0;
        end else begin
            if (load) begin
                r_shadowVal <= value;
                r_shadowDp  <= dpIn;
            end
            r_activeVal <= w_activeValNext;
            r_activeDp  <= w_activeDpNext;
            r_pending   <= w_pendingNext;
            r_idx       <= w_idxNext;
            r_hexOut    <= w_activeValNext[w_idxNext*4 +: 4];
            r_frameDone <= w_wrap;
            if (!enable) begin
                r_state   <= ST_BLANK;
                r_counter <= '0;
                r_digitN  <= '1;
            end else begin
                case (r_state)
                    ST_BLANK: begin
                        if (r_counter == DEAD_LAST) begin
                            r_counter <= '0;
                            r_state   <= ST_ON;
                            r_seg     <= segIn;
                            r_dp      <= ~r_activeDp[r_idx];
                            r_digitN  <= w_lit ? ~(DIGITS'(1) << r_idx) : '1;
                        end else begin
                            r_counter <= r_counter + CW'(1);
                        end
                    end
                    ST_ON: begin
                        if (r_counter == ON_LAST) begin
                            r_counter <= '0;
                            r_state   <= ST_BLANK;
                            r_digitN  <= '1;
                        end else begin
                            r_counter <= r_counter + CW'(1);
                        end
                    end
                    default: begin
                        r_state   <= ST_BLANK;
                        r_counter <= '0;
                        r_digitN  <= '1;
                    end
                endcase
            end
        end
    end

    assign hexOut    = r_hexOut;
    assign seg       = r_seg;
    assign dp        = r_dp;
    assign digitN    = r_digitN;
    assign frameDone = r_frameDone;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, ON=8, DEAD=2) with a behavioural hexToSeg7 decoder.
// Leading-zero blanking expectations follow SEG7_SCAN_LZB_EN when it is defined.
module tb_seg7_scan_driver;
    logic        clock;
    logic        resetN;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dpIn;
    logic [3:0]  hexOut;
    logic [6:0]  segIn;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  digitN;
    logic        frameDone;

    int testsRun  = 0;
    int failCount = 0;
    int cyc       = 0;

    seg7_scan_driver #(
        .DIGITS(4), .ON_CYCLES(8), .DEAD_CYCLES(2), .CW(4)
    ) dut (
        .clock(clock), .resetN(resetN), .enable(enable), .load(load),
        .value(value), .dpIn(dpIn), .hexOut(hexOut), .segIn(segIn),
        .seg(seg), .dp(dp), .digitN(digitN), .frameDone(frameDone)
    );

    // Active-low {a..g} hex font, standing in for the downstream decoder.
    function automatic logic [6:0] hexToSeg7Model(input logic [3:0] h);
        case (h)
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    assign segIn = hexToSeg7Model(hexOut);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic [3:0] dps);
        load  = ld;
        value = val;
        dpIn  = dps;
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    initial begin
        resetN = 1'b0;
        enable = 1'b1;
        applyStimulus(1'b0, 16'h0000, 4'h0);
        repeat (3) @(negedge clock);
        checkOutput("rst_digitN", 16'(digitN), 16'hF);
        checkOutput("rst_seg", 16'(seg), 16'h7F);
        checkOutput("rst_dp", 16'(dp), 16'h1);
        checkOutput("rst_hexOut", 16'(hexOut), 16'h0);
        checkOutput("rst_frameDone", 16'(frameDone), 16'h0);

        resetN = 1'b1;
        cyc = 0;
        checkOutput("c0_digitN", 16'(digitN), 16'hF);
        waitCycle(1);  checkOutput("c1_digitN", 16'(digitN), 16'hF);
        waitCycle(2);  checkOutput("c2_digitN", 16'(digitN), 16'hE);
        checkOutput("c2_seg", 16'(seg), 16'h01);
        checkOutput("c2_dp", 16'(dp), 16'h1);
        waitCycle(9);  checkOutput("c9_digitN", 16'(digitN), 16'hE);
        waitCycle(10); checkOutput("c10_digitN", 16'(digitN), 16'hF);
        waitCycle(11); checkOutput("c11_digitN", 16'(digitN), 16'hF);
        waitCycle(12); checkOutput("c12_digitN", 16'(digitN), 16'hD);

        // Shadowed load mid-frame must not show until the wrap.
        waitCycle(15); applyStimulus(1'b1, 16'h1234, 4'h0);
        waitCycle(16); applyStimulus(1'b0, 16'h0000, 4'h0);
        waitCycle(22); checkOutput("c22_digitN", 16'(digitN), 16'hB);
        checkOutput("c22_seg_old", 16'(seg), 16'h01);
        waitCycle(32); checkOutput("c32_digitN", 16'(digitN), 16'h7);
        checkOutput("c32_seg_old", 16'(seg), 16'h01);
        waitCycle(39); checkOutput("c39_frameDone", 16'(frameDone), 16'h0);
        waitCycle(40); checkOutput("c40_frameDone", 16'(frameDone), 16'h1);
        checkOutput("c40_digitN", 16'(digitN), 16'hF);
        checkOutput("c40_hexOut", 16'(hexOut), 16'h4);
        waitCycle(41); checkOutput("c41_frameDone", 16'(frameDone), 16'h0);
        waitCycle(42); checkOutput("c42_seg", 16'(seg), 16'h4C);
        checkOutput("c42_digitN", 16'(digitN), 16'hE);
        waitCycle(52); checkOutput("c52_seg", 16'(seg), 16'h06);
        waitCycle(62); checkOutput("c62_seg", 16'(seg), 16'h12);
        waitCycle(72); checkOutput("c72_seg", 16'(seg), 16'h4F);
        checkOutput("c72_digitN", 16'(digitN), 16'h7);

        // Load sampled on the wrap edge goes straight to the display.
        waitCycle(79); applyStimulus(1'b1, 16'hABCD, 4'h0);
        waitCycle(80); applyStimulus(1'b0, 16'h0000, 4'h0);
        checkOutput("c80_frameDone", 16'(frameDone), 16'h1);
        checkOutput("c80_hexOut", 16'(hexOut), 16'hD);
        waitCycle(82); checkOutput("c82_seg", 16'(seg), 16'h42);
        waitCycle(92); checkOutput("c92_seg", 16'(seg), 16'h31);
        waitCycle(102); checkOutput("c102_digitN", 16'(digitN), 16'hB);
        checkOutput("c102_seg", 16'(seg), 16'h60);

        waitCycle(104); enable = 1'b0;
        waitCycle(105); checkOutput("dis_digitN", 16'(digitN), 16'hF);
        checkOutput("dis_frameDone", 16'(frameDone), 16'h0);
        waitCycle(106); applyStimulus(1'b1, 16'h5678, 4'h1);
        waitCycle(107); applyStimulus(1'b0, 16'h0000, 4'h0);
        checkOutput("dis_seg_hold", 16'(seg), 16'h60);
        waitCycle(109); enable = 1'b1;
        waitCycle(110); checkOutput("en_digitN_blank", 16'(digitN), 16'hF);
        checkOutput("en_hexOut", 16'(hexOut), 16'h8);
        waitCycle(111); checkOutput("en_digitN_on", 16'(digitN), 16'hE);
        checkOutput("en_seg", 16'(seg), 16'h00);
        checkOutput("en_dp", 16'(dp), 16'h0);

        waitCycle(113); checkOutput("pre_rst_digitN", 16'(digitN), 16'hE);
        #2 resetN = 1'b0;
        #1;
        checkOutput("async_digitN", 16'(digitN), 16'hF);
        checkOutput("async_seg", 16'(seg), 16'h7F);
        checkOutput("async_dp", 16'(dp), 16'h1);
        checkOutput("async_hexOut", 16'(hexOut), 16'h0);
        @(negedge clock);
        resetN = 1'b1;
        cyc = 0;
        waitCycle(2); checkOutput("r2_seg_zero", 16'(seg), 16'h01);
        checkOutput("r2_dp", 16'(dp), 16'h1);

        waitCycle(3); applyStimulus(1'b1, 16'h0050, 4'h0);
        waitCycle(4); applyStimulus(1'b0, 16'h0000, 4'h0);
        waitCycle(42); checkOutput("z42_digitN", 16'(digitN), 16'hE);
        checkOutput("z42_seg", 16'(seg), 16'h01);
        waitCycle(52); checkOutput("z52_digitN", 16'(digitN), 16'hD);
        checkOutput("z52_seg", 16'(seg), 16'h24);
`ifdef SEG7_SCAN_LZB_EN
        waitCycle(62); checkOutput("z62_digitN", 16'(digitN), 16'hF);
        waitCycle(72); checkOutput("z72_digitN", 16'(digitN), 16'hF);
`else
        waitCycle(62); checkOutput("z62_digitN", 16'(digitN), 16'hB);
        waitCycle(72); checkOutput("z72_digitN", 16'(digitN), 16'h7);
`endif
        waitCycle(78); applyStimulus(1'b1, 16'h0000, 4'h0);
        waitCycle(79); applyStimulus(1'b0, 16'h0000, 4'h0);
        waitCycle(82); checkOutput("z82_digitN", 16'(digitN), 16'hE);
        checkOutput("z82_seg", 16'(seg), 16'h01);
`ifdef SEG7_SCAN_LZB_EN
        waitCycle(92); checkOutput("z92_digitN", 16'(digitN), 16'hF);
`else
        waitCycle(92); checkOutput("z92_digitN", 16'(digitN), 16'hD);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexes DIGITS hex nibbles onto one shared, active-low 7-segment bus with per-digit active-low enables.
- Sits directly upstream of the hexToSeg7 decoder. Drives the decoder's `hex` input with the current nibble, registers the decoder's `seg7` result back in, and drives the display pins.
- Double-buffered value load, dead-time between digits to prevent ghosting, and a frame-boundary pulse.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
ON_CYCLES, 1000, clocks each digit is lit (>=1)
DEAD_CYCLES, 16, clocks all digits are dark before each digit (>=1)
CW, 16, width of the phase counter; must hold max(ON_CYCLES, DEAD_CYCLES)-1

Ports:
clock  in  1  system clock, posedge
resetN  in  1  asynchronous reset, active-low
enable  in  1  scan enable; low forces display dark
load  in  1  one-cycle strobe; captures value/dpIn into the shadow
value  in  4*DIGITS  nibble i = value[4i+3:4i], digit 0 = least significant
dpIn  in  DIGITS  decimal points, active-high, bit i = digit i
hexOut  out  4  nibble to decoder (registered)
segIn  in  7  decoder output {a..g}, active-low, combinational from hexOut
seg  out  7  segment pins, active-low (registered)
dp  out  1  decimal-point pin, active-low (registered)
digitN  out  DIGITS  digit enables, active-low, at most one low
frameDone  out  1  one-cycle pulse at frame wrap

Behaviour:
- Reset (async assert, sync release):
  - Outputs: digitN = all 1, seg = 7'h7F, dp = 1, hexOut = 0, frameDone = 0.
  - Internal: idx = 0, state BLANK, counter = 0, shadow = active = 0, pending = 0.
- States: BLANK and ON; counter counts clocks within a state.
- BLANK:
  - digitN all 1, seg/dp held.
  - hexOut = active nibble[idx], valid from the first BLANK cycle.
  - On counter == DEAD_CYCLES-1: seg <= segIn, dp <= ~dpActive[idx], counter <= 0, go to ON. The decoder has at least one cycle to settle.
- ON:
  - digitN[idx] = 0, others 1.
  - On counter == ON_CYCLES-1: counter <= 0, go to BLANK.
  - Also idx <= idx+1, or 0 if idx == DIGITS-1.
- Wrap (ON exit with idx == DIGITS-1):
  - frameDone = 1 for exactly one cycle, aligned with the first BLANK cycle of digit 0.
  - If pending, active <= shadow and pending <= 0. The new nibble is used from that same BLANK cycle.
- Timing: digit period = DEAD_CYCLES+ON_CYCLES; frame = DIGITS × that.
- Load handling:
  - load=1 → shadow <= {value, dpIn}, pending <= 1.
  - load coincident with wrap → active takes the incoming value directly and pending stays 0.
  - Back-to-back loads: the last one wins.
- enable=0:
  - Next edge: digitN all 1, state BLANK, idx 0, counter 0, frameDone 0; seg/dp hold.
  - Loads are still accepted.
  - While enable=0 and pending=1, active <= shadow immediately.
- enable 0→1 restarts at BLANK of digit 0 with counter 0.
- Asynchronous reset mid-frame returns all outputs to their reset values in the same instant.
- Invariant: never more than one digitN bit low. seg changes only while all digitN are 1.

Optional Feature:
- Macro: SEG7_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - During the ON phase, a digit i > 0 stays dark (digitN all 1) if nibble i and every higher nibble of active are 0. Timing is unchanged.
  - Digit 0 is never blanked.
  - A set dpActive bit for digit i disables blanking of digit i and all lower digits.
- Undefined: every digit is lit every frame.

Test Plan (DIGITS=4, ON_CYCLES=8, DEAD_CYCLES=2, hexToSeg7 connected):
1. Release reset with enable=1 → digitN=1111 for cycles 0-1, 1110 for 2-9, 1111 for 10-11, 1101 for 12-19; seg=7'h01 (digit "0") from cycle 2; first frameDone at cycle 40.
2. load value=16'h1234 at cycle 15 → digits keep showing 0 until the frameDone at cycle 40; next frame's ON segs per digit 0..3 = 7'h4C, 7'h06, 7'h12, 7'h4F.
3. load 16'hABCD on the exact frameDone cycle → digit 0 in that same frame shows 7'h42 ("D"); no extra frame delay.
4. Deassert enable in the ON phase of digit 2 → next cycle digitN=1111; reassert → BLANK digit 0, digitN=1110 two cycles later.
5. Assert resetN=0 mid-ON, off a clock edge → digitN=1111, seg=7'h7F, dp=1 immediately; active returns to 0.
6. With SEG7_SCAN_LZB_EN, load 16'h0050 → digits 3 and 2 dark, digit 1 shows "5", digit 0 shows "0"; load 16'h0000 → only digit 0 lit.
